// File: rtl/mem_wb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_wb_if: MEM/WB pipeline bus (upstream controls and data in,   |
// | writeback view out).                                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mem_wb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall;
  logic                      flush;
  logic                      inValid;
  logic [DATA_WIDTH-1:0]     readMemoryWord;
  logic [DATA_WIDTH-1:0]     readALU;
  logic [REG_ADDR_WIDTH-1:0] readRD;
  logic [1:0]                WB;

  logic                      outValid;
  logic                      regWrite;
  logic                      memToReg;
  logic [REG_ADDR_WIDTH-1:0] RD;
  logic [DATA_WIDTH-1:0]     writeData;

  modport master (
    output stall, flush, inValid, readMemoryWord, readALU, readRD, WB,
    input  outValid, regWrite, memToReg, RD, writeData
  );

  modport slave (
    input  stall, flush, inValid, readMemoryWord, readALU, readRD, WB,
    output outValid, regWrite, memToReg, RD, writeData
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_wb_pipe: parametrised MEM/WB register, DEPTH stages with     |
// | valid/stall/flush, writeback mux and retired counter.            |
// | Optional forwarding lookup enabled by macro MEM_WB_FWD_EN.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_wb_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clock,
  input  logic                      resetN,
  mem_wb_if.slave                   bus,
  output logic [CNT_WIDTH-1:0]      retired
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0] rsQuery,
  input  logic [REG_ADDR_WIDTH-1:0] rtQuery,
  output logic                      rsHit,
  output logic                      rtHit,
  output logic [DATA_WIDTH-1:0]     rsData,
  output logic [DATA_WIDTH-1:0]     rtData
`endif
);

  logic [DEPTH-1:0]                     r_valid;
  logic [DEPTH-1:0]                     r_regWrite;
  logic [DEPTH-1:0]                     r_memToReg;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     r_memoryWord;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     r_aluResult;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] r_rd;
  logic [CNT_WIDTH-1:0]                 r_retired;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_valid      <= '0;
      r_regWrite   <= '0;
      r_memToReg   <= '0;
      r_memoryWord <= '0;
      r_aluResult  <= '0;
      r_rd         <= '0;
      r_retired    <= '0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        r_valid[0]      <= 1'b0;
        r_regWrite[0]   <= 1'b0;
        r_memToReg[0]   <= 1'b0;
        r_memoryWord[0] <= '0;
        r_aluResult[0]  <= '0;
        r_rd[0]         <= '0;
      end else begin
        r_valid[0]      <= bus.inValid;
        r_regWrite[0]   <= bus.WB[1];
        r_memToReg[0]   <= bus.WB[0];
        r_memoryWord[0] <= bus.readMemoryWord;
        r_aluResult[0]  <= bus.readALU;
        r_rd[0]         <= bus.readRD;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]      <= r_valid[i-1];
        r_regWrite[i]   <= r_regWrite[i-1];
        r_memToReg[i]   <= r_memToReg[i-1];
        r_memoryWord[i] <= r_memoryWord[i-1];
        r_aluResult[i]  <= r_aluResult[i-1];
        r_rd[i]         <= r_rd[i-1];
      end
      // The instruction leaving the last stage on this edge is the one retired.
      if (r_valid[DEPTH-1]) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.outValid  = r_valid[DEPTH-1];
  assign bus.regWrite  = r_valid[DEPTH-1] & r_regWrite[DEPTH-1];
  assign bus.memToReg  = r_memToReg[DEPTH-1];
  assign bus.RD        = r_rd[DEPTH-1];
  assign bus.writeData = r_memToReg[DEPTH-1] ? r_memoryWord[DEPTH-1] : r_aluResult[DEPTH-1];
  assign retired       = r_retired;

`ifdef MEM_WB_FWD_EN
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_stageData;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_stageData
      assign w_stageData[g] = r_memToReg[g] ? r_memoryWord[g] : r_aluResult[g];
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    rsHit  = 1'b0;
    rtHit  = 1'b0;
    rsData = '0;
    rtData = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_regWrite[i] && (rsQuery != '0) && (r_rd[i] == rsQuery)) begin
        rsHit  = 1'b1;
        rsData = w_stageData[i];
      end
      if (r_valid[i] && r_regWrite[i] && (rtQuery != '0) && (r_rd[i] == rtQuery)) begin
        rtHit  = 1'b1;
        rtData = w_stageData[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire
